// File: rtl/stall_mem_responder.sv
// -----------------------------------------------------------------------------
// stall_mem_responder
//
// Multi-cycle data memory that sits behind the processor's load/store path.
// It accepts one read or write and holds it for LATENCY cycles, asserting
// Stall while the request is in flight. It then completes the request with a
// one-cycle Done pulse. Storage is 2^DEPTH_LOG2 16-bit words, addressed by
// aligned byte addresses. The upper address bits are ignored, so the word
// index wraps.
//
// Parameters
//   LATENCY     cycles from acceptance to Done (1..15)
//   DEPTH_LOG2  log2 of the word count
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset (also clears the array)
//   Addr[15:0]   byte address; Addr[0] must be 0, word = Addr[DEPTH_LOG2:1]
//   DataIn[15:0] write data, sampled at acceptance
//   Rd, Wr       request strobes (exactly one may be high)
//   DataOut[15:0] registered read data, valid in the Done cycle, then held
//   Done         one-cycle completion pulse
//   Stall        request in flight, requester must hold
//   err          one-cycle pulse, illegal request rejected
//   o_dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: in IDLE a request (Rd xor Wr, aligned address) is accepted on the
// next rising edge. While BUSY/DONE, all request inputs are ignored and the
// latched copies are used. Done marks the single completion cycle. The
// following cycle is IDLE again, so a request that is still held there is
// accepted and executed once more.
// -----------------------------------------------------------------------------
module stall_mem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err,
  output logic [1:0]  o_dbg_state
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_is_wr;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [15:0]           r_wdata;
  logic [15:0]           r_dout;
  logic                  r_done;
  logic                  r_stall;
  logic                  r_err;
  logic [15:0]           r_mem [DEPTH];

  logic                  w_legal;
  logic                  w_illegal;
  logic                  w_accept;
  logic                  w_enter_done;
  logic                  w_acc_wr;
  logic [DEPTH_LOG2-1:0] w_acc_idx;
  logic [15:0]           w_acc_data;

  always_comb begin
    w_legal   = (Rd ^ Wr) && !Addr[0];
    w_illegal = (Rd || Wr) && !w_legal;
    w_accept  = (r_state == S_IDLE) && w_legal;
    // The array access happens on the edge that enters DONE. With LATENCY==1,
    // that edge is the acceptance edge itself, so the live inputs are used.
    // Otherwise the latched copies are used.
    w_enter_done = (w_accept && (LATENCY == 1)) ||
                   ((r_state == S_BUSY) && (r_cnt == 4'd1));
    if (r_state == S_IDLE) begin
      w_acc_wr   = Wr;
      w_acc_idx  = Addr[DEPTH_LOG2:1];
      w_acc_data = DataIn;
    end else begin
      w_acc_wr   = r_is_wr;
      w_acc_idx  = r_idx;
      w_acc_data = r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_is_wr <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 16'h0000;
      r_dout  <= 16'h0000;
      r_done  <= 1'b0;
      r_stall <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 16'h0000;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      // Writes commit and reads load DataOut only when entering DONE. A write
      // therefore never touches DataOut, and a later read sees the new word.
      if (w_enter_done) begin
        if (w_acc_wr) begin
          r_mem[w_acc_idx] <= w_acc_data;
        end else begin
          r_dout <= r_mem[w_acc_idx];
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_wr <= Wr;
            r_idx   <= Addr[DEPTH_LOG2:1];
            r_wdata <= DataIn;
            r_cnt   <= LAT_M1;
            if (LATENCY == 1) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_BUSY;
              r_stall <= 1'b1;
            end
          end else if (w_illegal) begin
            r_err <= 1'b1;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_stall <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign DataOut     = r_dout;
  assign Done        = r_done;
  assign Stall       = r_stall;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stall_mem_responder.sv
// -----------------------------------------------------------------------------
// Bench for stall_mem_responder.
//
// The main instance uses LATENCY=4. A second instance with LATENCY=1 covers
// the single-cycle variant.
//
// Each issued request pushes {is_err, response cycle, expected DataOut} onto
// exp_q. The monitor pops an entry whenever the main instance shows Done or
// err, and compares the response kind, arrival cycle and DataOut. If an
// expected response passes its cycle without appearing, the monitor reports
// it as missing.
// -----------------------------------------------------------------------------
module tb_stall_mem_responder;

  localparam int LAT = 4;
  localparam int W   = 49;  // [48] is_err, [47:16] cycle, [15:0] data

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr = 16'h0, DataIn = 16'h0;
  logic        Rd = 1'b0, Wr = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, err;
  logic [1:0]  dbg_state;

  logic [15:0] Addr1 = 16'h0, DataIn1 = 16'h0;
  logic        Rd1 = 1'b0, Wr1 = 1'b0;
  logic [15:0] DataOut1;
  logic        Done1, Stall1, err1;
  logic [1:0]  dbg_state1;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [15:0]  model_dout = 16'h0000;

  stall_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .err(err),
    .o_dbg_state(dbg_state)
  );

  stall_mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
    .clk(clk), .rst(rst), .Addr(Addr1), .DataIn(DataIn1), .Rd(Rd1), .Wr(Wr1),
    .DataOut(DataOut1), .Done(Done1), .Stall(Stall1), .err(err1),
    .o_dbg_state(dbg_state1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (Done || err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'({Done, err}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_err",   32'(err),  32'(mon_e[48]));
        chk("resp_done",  32'(Done), 32'(!mon_e[48]));
        chk("resp_cycle", 32'(cyc),  mon_e[47:16]);
        if (!mon_e[48]) chk("resp_dout", 32'(DataOut), 32'(mon_e[15:0]));
        else            chk("err_stall", 32'(Stall), 32'd0);
      end
    end else if (exp_q.size() != 0 && 32'(cyc) > exp_q[0][47:16]) begin
      mon_e = exp_q.pop_front();
      chk("missing_resp", 32'(cyc), mon_e[47:16]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic req(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] data, input logic is_err,
                     input logic [15:0] exp_dout, input logic scramble);
    int t0;
    int span;
    @(negedge clk);
    Rd = rd; Wr = wr; Addr = addr; DataIn = data;
    t0 = cyc;
    span = is_err ? 1 : LAT;
    exp_q.push_back({is_err, 32'(t0 + span), exp_dout});
    for (int k = 1; k <= span; k++) begin
      @(negedge clk);
      if (k == 1) begin Rd = 1'b0; Wr = 1'b0; end
      if (scramble && k == 2) begin
        Rd = !rd; Wr = !wr; Addr = addr ^ 16'h0006; DataIn = ~data;
      end
      if (k == span) begin Rd = 1'b0; Wr = 1'b0; end
      chk("stall", 32'(Stall), 32'(!is_err && k < span));
    end
  endtask

  task automatic wr_req(input logic [15:0] addr, input logic [15:0] data, input logic scramble);
    req(1'b0, 1'b1, addr, data, 1'b0, model_dout, scramble);
  endtask

  task automatic rd_req(input logic [15:0] addr, input logic [15:0] exp, input logic scramble);
    model_dout = exp;
    req(1'b1, 1'b0, addr, 16'h0000, 1'b0, exp, scramble);
  endtask

  task automatic bad_req(input logic rd, input logic wr, input logic [15:0] addr);
    req(rd, wr, addr, 16'h9999, 1'b1, 16'h0000, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    // reset values while rst is held
    repeat (3) begin
      @(negedge clk);
      chk("rst_flags", 32'({Done, Stall, err}), 32'd0);
      chk("rst_dout",  32'(DataOut), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
    end
    rst = 1'b0;

    // reset contents read as zero
    rd_req(16'h00FE, 16'h0000, 1'b0);

    // write then read, DataOut held afterwards
    wr_req(16'h0010, 16'hBEEF, 1'b0);
    rd_req(16'h0010, 16'hBEEF, 1'b0);
    repeat (11) @(negedge clk);
    chk("dout_hold", 32'(DataOut), 32'hBEEF);

    // illegal requests
    wr_req(16'h0004, 16'h1111, 1'b0);
    bad_req(1'b1, 1'b1, 16'h0004);
    rd_req(16'h0004, 16'h1111, 1'b0);
    bad_req(1'b1, 1'b0, 16'h0003);
    bad_req(1'b0, 1'b1, 16'h0005);
    rd_req(16'h0004, 16'h1111, 1'b0);

    // inputs changed while BUSY must be ignored
    wr_req(16'h0008, 16'h7777, 1'b1);
    rd_req(16'h000E, 16'h0000, 1'b0);
    rd_req(16'h0008, 16'h7777, 1'b1);
    rd_req(16'h000E, 16'h0000, 1'b0);

    // reset mid-write aborts the write and clears the array
    @(negedge clk);
    Wr = 1'b1; Addr = 16'h0020; DataIn = 16'h1234;
    @(negedge clk);
    Wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_flags", 32'({Done, Stall, err}), 32'd0);
    chk("midrst_dout",  32'(DataOut), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    model_dout = 16'h0000;
    rd_req(16'h0020, 16'h0000, 1'b0);
    rd_req(16'h0004, 16'h0000, 1'b0);

    // aliasing plus a continuously held read
    wr_req(16'h0202, 16'hAAAA, 1'b0);
    @(negedge clk);
    Rd = 1'b1; Wr = 1'b0; Addr = 16'h0002;
    t0 = cyc;
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back({1'b0, 32'(t0 + LAT + j * (LAT + 1)), 16'hAAAA});
    end
    repeat (3 * (LAT + 1)) @(negedge clk);
    Rd = 1'b0;
    model_dout = 16'hAAAA;
    repeat (4) @(negedge clk);

    // LATENCY=1 instance: Done the cycle after acceptance, never Stall
    @(negedge clk);
    Wr1 = 1'b1; Addr1 = 16'h0006; DataIn1 = 16'h5555;
    @(negedge clk);
    chk("l1_wr_done",  32'(Done1),    32'd1);
    chk("l1_wr_stall", 32'(Stall1),   32'd0);
    chk("l1_wr_dout",  32'(DataOut1), 32'd0);
    Wr1 = 1'b0;
    @(negedge clk);
    chk("l1_idle_done", 32'(Done1), 32'd0);
    Rd1 = 1'b1;
    @(negedge clk);
    chk("l1_rd_done",  32'(Done1),    32'd1);
    chk("l1_rd_stall", 32'(Stall1),   32'd0);
    chk("l1_rd_dout",  32'(DataOut1), 32'h5555);
    Rd1 = 1'b0;
    @(negedge clk);
    chk("l1_after_done", 32'(Done1), 32'd0);
    chk("l1_err",        32'(err1),  32'd0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
